// File: rtl/inst_cache_pkg.sv
// ---------------------------------------------------------------------------
// inst_cache_pkg : shared constants and FSM encoding for the instruction cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package inst_cache_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic LOW   = 1'b0;

  typedef enum logic [0:0] {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

`default_nettype wire

// File: rtl/inst_cache_if.sv
// ---------------------------------------------------------------------------
// inst_cache_if : fetch-side and memory-side bus of the instruction cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface inst_cache_if;

  logic        rdy;
  logic        pc_valid;
  logic [31:0] pc;
  logic        flush;
  logic        inst_ready;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  // cache side
  modport slave (
    input  rdy, pc_valid, pc, flush, mem_done, mem_data,
    output inst_ready, inst, mem_req, mem_addr
  );

  // fetch stage + memory controller side
  modport master (
    output rdy, pc_valid, pc, flush, mem_done, mem_data,
    input  inst_ready, inst, mem_req, mem_addr
  );

endinterface

`default_nettype wire

// File: rtl/icache_line_store.sv
// ---------------------------------------------------------------------------
// icache_line_store : tag/valid/data arrays, async read, word write, line commit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_line_store
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int OFF_BITS   = 2,
  parameter int TAG_BITS   = 22
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [INDEX_BITS-1:0] i_rd_index,
  input  wire logic [OFF_BITS-1:0]   i_rd_offset,
  input  wire logic [TAG_BITS-1:0]   i_rd_tag,
  output logic                       o_hit,
  output logic [31:0]                o_word,
  input  wire logic                  i_wr_en,
  input  wire logic [INDEX_BITS-1:0] i_wr_index,
  input  wire logic [OFF_BITS-1:0]   i_wr_offset,
  input  wire logic [31:0]           i_wr_data,
  input  wire logic                  i_commit_en,
  input  wire logic [INDEX_BITS-1:0] i_commit_index,
  input  wire logic [TAG_BITS-1:0]   i_commit_tag,
  input  wire logic                  i_inv_en,
  input  wire logic [INDEX_BITS-1:0] i_inv_index
);

  localparam int LINES      = 1 << INDEX_BITS;
  localparam int LINE_WORDS = 1 << OFF_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES][LINE_WORDS];

  // invalidate and commit never target the same cycle: one is IDLE-only, the other REFILL-only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en)    r_valid[i_inv_index]    <= LOW;
      if (i_commit_en) r_valid[i_commit_index] <= HIGH;
    end
  end

  always_ff @(posedge clk) begin
    if (i_commit_en) r_tag[i_commit_index] <= i_commit_tag;
    if (i_wr_en)     r_data[i_wr_index][i_wr_offset] <= i_wr_data;
  end

  assign o_hit  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_word = r_data[i_rd_index][i_rd_offset];

endmodule

`default_nettype wire

// File: rtl/inst_cache.sv
// ---------------------------------------------------------------------------
// inst_cache : direct-mapped read-only instruction cache with word-wise line refill
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  inst_cache_if.slave bus
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS = 32 - 2 - OFF_BITS - INDEX_BITS;
  localparam logic [OFF_BITS-1:0] C_LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

  icache_state_e         r_state;
  logic [OFF_BITS-1:0]   r_cnt;
  logic [TAG_BITS-1:0]   r_line_tag;
  logic [INDEX_BITS-1:0] r_line_idx;
  logic                  r_inst_ready;
  logic [31:0]           r_inst;
  logic                  r_mem_req;
  logic [31:0]           r_mem_addr;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [OFF_BITS-1:0]   w_off;
  logic                  w_hit;
  logic [31:0]           w_word;
  logic                  w_lookup;
  logic                  w_last;
  logic                  w_wr_en;
  logic                  w_inv_en;

  assign w_tag   = bus.pc[31 -: TAG_BITS];
  assign w_index = bus.pc[2+OFF_BITS +: INDEX_BITS];
  assign w_off   = bus.pc[2 +: OFF_BITS];

  // the cycle after a response is a cooldown so a held request is not served twice
  assign w_lookup = bus.pc_valid && !bus.flush && !r_inst_ready;
  assign w_last   = (r_cnt == C_LAST_WORD);
  assign w_wr_en  = !rst && bus.rdy && (r_state == ICACHE_REFILL) && bus.mem_done;
  assign w_inv_en = !rst && bus.rdy && (r_state == ICACHE_IDLE) && w_lookup && !w_hit;

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .OFF_BITS   (OFF_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk            (clk),
    .rst            (rst),
    .i_rd_index     (w_index),
    .i_rd_offset    (w_off),
    .i_rd_tag       (w_tag),
    .o_hit          (w_hit),
    .o_word         (w_word),
    .i_wr_en        (w_wr_en),
    .i_wr_index     (r_line_idx),
    .i_wr_offset    (r_cnt),
    .i_wr_data      (bus.mem_data),
    .i_commit_en    (w_wr_en && w_last),
    .i_commit_index (r_line_idx),
    .i_commit_tag   (r_line_tag),
    .i_inv_en       (w_inv_en),
    .i_inv_index    (w_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ICACHE_IDLE;
      r_cnt        <= '0;
      r_line_tag   <= '0;
      r_line_idx   <= '0;
      r_inst_ready <= FALSE;
      r_inst       <= '0;
      r_mem_req    <= LOW;
      r_mem_addr   <= '0;
    end else if (!bus.rdy) begin
      r_inst_ready <= FALSE;
    end else begin
      r_inst_ready <= FALSE;
      case (r_state)
        ICACHE_IDLE: begin
          if (w_lookup) begin
            if (w_hit) begin
              r_inst       <= w_word;
              r_inst_ready <= TRUE;
            end else begin
              r_line_tag <= w_tag;
              r_line_idx <= w_index;
              r_cnt      <= '0;
              r_mem_req  <= HIGH;
              r_mem_addr <= {bus.pc[31:2+OFF_BITS], {(OFF_BITS+2){1'b0}}};
              r_state    <= ICACHE_REFILL;
            end
          end
        end
        ICACHE_REFILL: begin
          // flush does not stop a refill; memory transactions always complete
          if (bus.mem_done) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_mem_req <= LOW;
              r_state   <= ICACHE_IDLE;
            end else begin
              r_mem_addr <= r_mem_addr + 32'd4;
            end
          end
        end
        default: r_state <= ICACHE_IDLE;
      endcase
    end
  end

  assign bus.inst_ready = r_inst_ready;
  assign bus.inst       = r_inst;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_inst_cache.sv
// ---------------------------------------------------------------------------
// tb_inst_cache : directed tests plus a per-cycle rule model of the cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_cache;

  localparam int LW = 4;
  localparam int IB = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_cache_if bus ();

  inst_cache #(.INDEX_BITS(IB), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic        auto_done = 1'b0;
  logic [31:0] auto_data = '0;
  logic        inj_done  = 1'b0;
  logic [31:0] inj_data  = '0;
  logic        resp_en   = 1'b1;
  assign bus.mem_done = auto_done | inj_done;
  assign bus.mem_data = inj_done ? inj_data : auto_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  logic [31:0] acc_addrs[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'h13 + (a >> 2);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory controller: answers each outstanding request after a short wait
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (auto_done) begin
        auto_done = 1'b0;
      end else if (resp_en && bus.rdy && bus.mem_req && !rst) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          auto_done = 1'b1;
          auto_data = mem_word(bus.mem_addr);
          wait_cnt  = 0;
        end
      end
    end
  end

  // ---------------- rule model, checked every cycle ----------------
  typedef struct {
    logic        rst, rdy, pc_valid, flush, mem_done, inst_ready, mem_req;
    logic [31:0] pc, mem_addr, inst;
  } snap_t;

  logic        m_valid [1<<IB];
  logic [21:0] m_tag   [1<<IB];
  logic [31:0] m_base = '0;
  int          m_words = 0;

  function automatic logic m_hit(logic [31:0] a);
    return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
  endfunction

  initial begin
    snap_t s;
    logic  have, h;
    have = 1'b0;
    for (int i = 0; i < (1<<IB); i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
    forever begin
      @(negedge clk);
      if (have) begin
        if (s.rst) begin
          chk("rst inst_ready", bus.inst_ready, 0);
          chk("rst mem_req", bus.mem_req, 0);
          chk("rst mem_addr", bus.mem_addr, 0);
          chk("rst inst", bus.inst, 0);
          for (int i = 0; i < (1<<IB); i++) m_valid[i] = 1'b0;
          m_words = 0;
        end else if (!s.rdy) begin
          chk("frozen inst_ready", bus.inst_ready, 0);
          chk("frozen mem_req", bus.mem_req, s.mem_req);
          chk("frozen mem_addr", bus.mem_addr, s.mem_addr);
          chk("frozen inst", bus.inst, s.inst);
        end else if (!s.mem_req && s.pc_valid && !s.flush && !s.inst_ready) begin
          h = m_hit(s.pc);
          chk("lookup inst_ready", bus.inst_ready, h);
          chk("lookup mem_req", bus.mem_req, !h);
          if (h) begin
            chk("hit inst", bus.inst, mem_word({s.pc[31:2], 2'b00}));
          end else begin
            chk("miss mem_addr", bus.mem_addr, {s.pc[31:4], 4'h0});
            chk("miss inst hold", bus.inst, s.inst);
            m_valid[s.pc[9:4]] = 1'b0;
            m_base  = {s.pc[31:4], 4'h0};
            m_words = 0;
          end
        end else if (!s.mem_req) begin
          chk("idle inst_ready", bus.inst_ready, 0);
          chk("idle mem_req", bus.mem_req, 0);
          chk("idle inst hold", bus.inst, s.inst);
        end else begin
          chk("refill inst_ready", bus.inst_ready, 0);
          chk("refill inst hold", bus.inst, s.inst);
          if (s.mem_done) begin
            chk("refill word addr", s.mem_addr, m_base + 32'(4 * m_words));
            acc_addrs.push_back(s.mem_addr);
            acc_cnt++;
            last_acc_cyc = cyc;
            m_words++;
            if (m_words == LW) begin
              chk("refill end mem_req", bus.mem_req, 0);
              m_valid[m_base[9:4]] = 1'b1;
              m_tag[m_base[9:4]]   = m_base[31:10];
            end else begin
              chk("refill next mem_req", bus.mem_req, 1);
              chk("refill next addr", bus.mem_addr, s.mem_addr + 32'd4);
            end
          end else begin
            chk("refill wait mem_req", bus.mem_req, 1);
            chk("refill wait addr", bus.mem_addr, s.mem_addr);
          end
        end
      end
      s.rst = rst;          s.rdy = bus.rdy;           s.pc_valid = bus.pc_valid;
      s.flush = bus.flush;  s.mem_done = bus.mem_done; s.inst_ready = bus.inst_ready;
      s.mem_req = bus.mem_req; s.pc = bus.pc; s.mem_addr = bus.mem_addr; s.inst = bus.inst;
      have = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (1) begin
      tick();
      edges++;
      if (bus.inst_ready) break;
      if (edges > 400) begin chk("timeout inst_ready", 0, 1); break; end
    end
  endtask

  task automatic wait_acc(int target);
    int n;
    n = 0;
    while (acc_cnt < target) begin
      tick();
      n++;
      if (n > 400) begin chk("timeout refill word", acc_cnt, target); break; end
    end
  endtask

  // full fetch: request, wait for the word, hold through the consume edge
  task automatic fetch(input logic [31:0] a, output int edges, output int ntx,
                       output int lat, output logic [31:0] got);
    int a0;
    a0 = acc_cnt;
    bus.pc = a;
    bus.pc_valid = 1'b1;
    wait_ready(edges);
    got = bus.inst;
    ntx = acc_cnt - a0;
    lat = cyc - last_acc_cyc;
    tick();
    chk("cooldown inst_ready", bus.inst_ready, 0);
    bus.pc_valid = 1'b0;
  endtask

  initial begin
    int e, n, l, a0, pulses;
    logic [31:0] w, saved_addr;
    bus.rdy = 1'b1; bus.pc_valid = 1'b0; bus.pc = '0; bus.flush = 1'b0;
    repeat (3) tick();
    chk("reset inst_ready", bus.inst_ready, 0);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset inst", bus.inst, 0);
    rst = 1'b0;
    tick();

    // 1: cold miss
    acc_addrs.delete();
    fetch(32'h0, e, n, l, w);
    chk("t1 txns", n, 4);
    chk("t1 inst", w, 32'h00000013);
    chk("t1 latency after last word", l, 1);
    for (int i = 0; i < 4 && i < acc_addrs.size(); i++) chk("t1 addr", acc_addrs[i], 32'(4 * i));

    // 2: hit in same line
    fetch(32'h8, e, n, l, w);
    chk("t2 edges", e, 1);
    chk("t2 txns", n, 0);
    chk("t2 inst", w, 32'h00000015);

    // 3: held request answered once
    pulses = 0;
    bus.pc = 32'h4; bus.pc_valid = 1'b1;
    tick(); if (bus.inst_ready) pulses++;
    chk("t3 inst", bus.inst, 32'h00000014);
    tick(); if (bus.inst_ready) pulses++;
    chk("t3 cooldown", bus.inst_ready, 0);
    bus.pc_valid = 1'b0;
    repeat (2) begin tick(); if (bus.inst_ready) pulses++; end
    chk("t3 pulses", pulses, 1);

    // 4: conflict eviction
    acc_addrs.delete();
    fetch(32'h400, e, n, l, w);
    chk("t4 txns 0x400", n, 4);
    if (acc_addrs.size() > 0) chk("t4 first addr", acc_addrs[0], 32'h400);
    chk("t4 inst 0x400", w, 32'h00000113);
    fetch(32'h0, e, n, l, w);
    chk("t4 refetch txns", n, 4);
    chk("t4 refetch inst", w, 32'h00000013);

    // 5: flush mid-refill
    fetch(32'h400, e, n, l, w);
    a0 = acc_cnt;
    bus.pc = 32'h0; bus.pc_valid = 1'b1;
    wait_acc(a0 + 2);
    a0 = acc_cnt;
    bus.pc = 32'h20; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t5 flush inst_ready", bus.inst_ready, 0);
    wait_ready(e);
    chk("t5 txns before answer", acc_cnt - a0, 6);
    chk("t5 inst 0x20", bus.inst, 32'h0000001B);
    tick();
    bus.pc_valid = 1'b0;
    fetch(32'h0, e, n, l, w);
    chk("t5 0x0 hit txns", n, 0);
    chk("t5 0x0 inst", w, 32'h00000013);

    // 6: freeze mid-refill with a stray mem_done
    a0 = acc_cnt;
    bus.pc = 32'h40; bus.pc_valid = 1'b1;
    wait_acc(a0 + 1);
    resp_en = 1'b0;
    repeat (3) tick();
    saved_addr = bus.mem_addr;
    a0 = acc_cnt;
    bus.rdy = 1'b0;
    repeat (2) tick();
    inj_data = 32'hDEADBEEF; inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (2) tick();
    chk("t6 frozen addr", bus.mem_addr, saved_addr);
    chk("t6 frozen words", acc_cnt, a0);
    chk("t6 frozen mem_req", bus.mem_req, 1);
    bus.rdy = 1'b1; resp_en = 1'b1;
    wait_ready(e);
    chk("t6 inst 0x40", bus.inst, 32'h00000023);
    tick();
    bus.pc_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      fetch(32'h40 + 32'(4 * k), e, n, l, w);
      chk("t6 word txns", n, 0);
      chk("t6 word", w, 32'h23 + 32'(k));
    end

    // reset mid-refill
    a0 = acc_cnt;
    bus.pc = 32'h80; bus.pc_valid = 1'b1;
    wait_acc(a0 + 1);
    rst = 1'b1; bus.pc_valid = 1'b0;
    tick();
    chk("rst abort mem_req", bus.mem_req, 0);
    rst = 1'b0;
    tick();
    fetch(32'h0, e, n, l, w);
    chk("post-rst txns", n, 4);
    chk("post-rst inst", w, 32'h00000013);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
